// File: rtl/ddr2_sched_pkg.sv
// ddr2_sched_pkg: shared types, constants and buffer-rotation helper for the DDR2 line scheduler.
//   state_t       : scheduler FSM states
//   buf_t         : frame buffer index (0..NUM_BUFS-1)
//   next_free_buf : lowest buffer index equal to neither argument
package ddr2_sched_pkg;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, GAP} state_t;
  typedef logic [1:0] buf_t;
  localparam int NUM_BUFS = 3;
  function automatic buf_t next_free_buf(input buf_t a, input buf_t b);
    next_free_buf = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--)
      if (buf_t'(i) != a && buf_t'(i) != b) next_free_buf = buf_t'(i);
  endfunction
endpackage

// File: rtl/ddr2_line_scheduler_if.sv
// ddr2_line_scheduler_if: requester, controller and frame-store signals of the line scheduler.
//   master : scheduler side (takes requests/beats, drives strobes, acks, buffer/line state)
//   slave  : environment side (capture, display and DDR2 controller)
interface ddr2_line_scheduler_if
  import ddr2_sched_pkg::*;
#(
  parameter int LINE_W = 11
);
  logic cap_line_req, cap_frame_end, cap_line_ack;
  logic disp_line_req, disp_frame_start, disp_urgent, disp_line_ack;
  logic ddr_wr_req, ddr_rd_req, ddr_wr_beat, ddr_rd_beat;
  buf_t wr_buf_sel, rd_buf_sel;
  logic [LINE_W-1:0] wr_line_idx, rd_line_idx;
  logic busy, timeout_err;
  modport master (
    input  cap_line_req, cap_frame_end, disp_line_req, disp_frame_start, disp_urgent,
    input  ddr_wr_beat, ddr_rd_beat,
    output cap_line_ack, disp_line_ack, ddr_wr_req, ddr_rd_req,
    output wr_buf_sel, rd_buf_sel, wr_line_idx, rd_line_idx, busy, timeout_err
  );
  modport slave (
    output cap_line_req, cap_frame_end, disp_line_req, disp_frame_start, disp_urgent,
    output ddr_wr_beat, ddr_rd_beat,
    input  cap_line_ack, disp_line_ack, ddr_wr_req, ddr_rd_req,
    input  wr_buf_sel, rd_buf_sel, wr_line_idx, rd_line_idx, busy, timeout_err
  );
endinterface

// File: rtl/ddr2_burst_counter.sv
// ddr2_burst_counter: beat and beat-starvation counters for the active line burst.
//   clk, rst_n : clock, async active-low reset
//   active     : a burst is in progress (counters clear while low)
//   beat       : accepted pixel of the active direction
//   done       : this beat completes the line
//   timeout    : this cycle is the TIMEOUT_CYC-th consecutive cycle without a beat
module ddr2_burst_counter #(
  parameter int LINE_PIXELS = 1920,
  parameter int LINE_W      = 11,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic beat,
  output logic done,
  output logic timeout
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [LINE_W-1:0] beat_cnt;
  logic [TO_W-1:0] idle_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      beat_cnt <= !active ? '0 : beat ? beat_cnt + LINE_W'(1) : beat_cnt;
      idle_cnt <= (!active || beat) ? '0 : idle_cnt + TO_W'(1);
    end
  end
  assign done    = active & beat & (beat_cnt == LINE_W'(LINE_PIXELS - 1));
  assign timeout = active & ~beat & (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/ddr2_line_scheduler.sv
// ddr2_line_scheduler: arbitrates capture writes and display reads onto one DDR2 line port
// and rotates a triple-buffered frame store.
//   clk, rst_n : clock, async active-low reset
//   bus        : ddr2_line_scheduler_if.master (requests, strobes, beats, acks, buffer/line state)
module ddr2_line_scheduler
  import ddr2_sched_pkg::*;
#(
  parameter int LINE_PIXELS = 1920,
  parameter int LINE_W      = 11,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic clk,
  input logic rst_n,
  ddr2_line_scheduler_if.master bus
);
  state_t state, state_nx;
  logic first, wr_pend, rd_pend, rr_last, wr_fe_hold, rd_fs_hold;
  logic in_wr, in_rd, cnt_done, cnt_to, wr_end, rd_end;
  logic grant_wr, grant_rd, apply_wr, apply_rd;
  buf_t last_done, rd_buf_nx;

  assign in_wr = state == WR_BURST;
  assign in_rd = state == RD_BURST;
  // rr_last = 1 means the last contested grant went to the reader
  assign grant_rd = (state == IDLE) & rd_pend & (~wr_pend | bus.disp_urgent | ~rr_last);
  assign grant_wr = (state == IDLE) & wr_pend & ~grant_rd;
  assign wr_end = in_wr & (cnt_done | cnt_to);
  assign rd_end = in_rd & (cnt_done | cnt_to);
  // frame events are deferred while their own direction is mid-line
  assign apply_wr = (bus.cap_frame_end | wr_fe_hold) & (~in_wr | wr_end);
  assign apply_rd = (bus.disp_frame_start | rd_fs_hold) & (~in_rd | rd_end);
  // the writer picks its next buffer against the reader's post-update buffer
  assign rd_buf_nx = apply_rd ? last_done : bus.rd_buf_sel;

  ddr2_burst_counter #(
    .LINE_PIXELS(LINE_PIXELS),
    .LINE_W     (LINE_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (in_wr | in_rd),
    .beat   (in_wr ? bus.ddr_wr_beat : bus.ddr_rd_beat),
    .done   (cnt_done),
    .timeout(cnt_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      first <= 1'b0;
    end else begin
      state <= state_nx;
      first <= grant_wr | grant_rd;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = grant_wr ? WR_BURST : grant_rd ? RD_BURST : IDLE;
      WR_BURST: state_nx = wr_end ? GAP : WR_BURST;
      RD_BURST: state_nx = rd_end ? GAP : RD_BURST;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = state != IDLE;
    bus.ddr_wr_req = in_wr & first;
    bus.ddr_rd_req = in_rd & first;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend           <= 1'b0;
      rd_pend           <= 1'b0;
      rr_last           <= 1'b1;
      wr_fe_hold        <= 1'b0;
      rd_fs_hold        <= 1'b0;
      last_done         <= '0;
      bus.wr_buf_sel    <= buf_t'(1);
      bus.rd_buf_sel    <= '0;
      bus.wr_line_idx   <= '0;
      bus.rd_line_idx   <= '0;
      bus.cap_line_ack  <= 1'b0;
      bus.disp_line_ack <= 1'b0;
      bus.timeout_err   <= 1'b0;
    end else begin
      // an aborted burst re-raises its requester for a retry
      wr_pend           <= ~grant_wr & (wr_pend | bus.cap_line_req | (in_wr & cnt_to));
      rd_pend           <= ~grant_rd & (rd_pend | bus.disp_line_req | (in_rd & cnt_to));
      rr_last           <= (state == IDLE && wr_pend && rd_pend) ? grant_rd : rr_last;
      wr_fe_hold        <= (bus.cap_frame_end | wr_fe_hold) & ~apply_wr;
      rd_fs_hold        <= (bus.disp_frame_start | rd_fs_hold) & ~apply_rd;
      bus.cap_line_ack  <= in_wr & cnt_done;
      bus.disp_line_ack <= in_rd & cnt_done;
      bus.timeout_err   <= bus.timeout_err | cnt_to;
      bus.wr_line_idx   <= apply_wr ? '0 : bus.wr_line_idx + LINE_W'(in_wr & cnt_done);
      bus.rd_line_idx   <= apply_rd ? '0 : bus.rd_line_idx + LINE_W'(in_rd & cnt_done);
      bus.rd_buf_sel    <= rd_buf_nx;
      last_done         <= apply_wr ? bus.wr_buf_sel : last_done;
      bus.wr_buf_sel    <= apply_wr ? next_free_buf(rd_buf_nx, bus.wr_buf_sel) : bus.wr_buf_sel;
    end
  end
endmodule

// File: tb/tb_ddr2_line_scheduler.sv
// tb_ddr2_line_scheduler: directed and randomized bench with an event scoreboard for ddr2_line_scheduler.
module tb_ddr2_line_scheduler;
  localparam int LP = 4;
  localparam int LW = 3;
  localparam int TO = 8;
  localparam int P_IDLE = 0, P_WR = 1, P_RD = 2, P_GAP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr2_line_scheduler_if #(.LINE_W(LW)) bus ();
  ddr2_line_scheduler #(.LINE_PIXELS(LP), .LINE_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int cyc;
    logic [3:0] ev;
    int wb, rb, wl, rl;
    bit terr;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // reference model: a line transfer is a transaction of LP beats or TO starved cycles
  int m_cyc = 0, ph, m_beats, m_idle, m_wb, m_rb, m_ld, m_wl, m_rl;
  bit m_first, m_wp, m_rp, m_rr_rd, m_wfe, m_rfe, m_terr, m_wack, m_rack;

  task automatic model_reset();
    ph = P_IDLE; m_beats = 0; m_idle = 0;
    m_wb = 1; m_rb = 0; m_ld = 0; m_wl = 0; m_rl = 0;
    m_first = 0; m_wp = 0; m_rp = 0; m_rr_rd = 1; m_wfe = 0; m_rfe = 0;
    m_terr = 0; m_wack = 0; m_rack = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit beat, fin_ok, fin_to, wend, rend, aw, ar, nwp, nrp, g_rd;
    int old_wb;
    logic [3:0] ev;
    m_cyc++;
    fin_ok = 0; fin_to = 0; m_wack = 0; m_rack = 0;
    if (ph == P_WR || ph == P_RD) begin
      beat = (ph == P_WR) ? bus.ddr_wr_beat : bus.ddr_rd_beat;
      if (beat) begin m_beats++; m_idle = 0; end else m_idle++;
      fin_ok = m_beats == LP;
      fin_to = m_idle == TO;
    end
    wend = (ph == P_WR) && (fin_ok || fin_to);
    rend = (ph == P_RD) && (fin_ok || fin_to);
    aw = (bus.cap_frame_end || m_wfe) && (ph != P_WR || wend);
    ar = (bus.disp_frame_start || m_rfe) && (ph != P_RD || rend);
    m_wfe = (bus.cap_frame_end || m_wfe) && !aw;
    m_rfe = (bus.disp_frame_start || m_rfe) && !ar;
    if (wend && fin_ok) begin m_wack = 1; m_wl = (m_wl + 1) % (1 << LW); end
    if (rend && fin_ok) begin m_rack = 1; m_rl = (m_rl + 1) % (1 << LW); end
    if (fin_to) m_terr = 1;
    nwp = m_wp || bus.cap_line_req || (ph == P_WR && fin_to);
    nrp = m_rp || bus.disp_line_req || (ph == P_RD && fin_to);
    m_first = 0;
    case (ph)
      P_IDLE: if (m_wp || m_rp) begin
        g_rd = m_rp && (!m_wp || bus.disp_urgent || !m_rr_rd);
        if (m_wp && m_rp) m_rr_rd = g_rd;
        if (g_rd) begin nrp = 0; ph = P_RD; end else begin nwp = 0; ph = P_WR; end
        m_first = 1; m_beats = 0; m_idle = 0;
      end
      P_WR, P_RD: if (fin_ok || fin_to) ph = P_GAP;
      default: ph = P_IDLE;
    endcase
    m_wp = nwp; m_rp = nrp;
    if (ar) begin m_rb = m_ld; m_rl = 0; end
    if (aw) begin
      old_wb = m_wb;
      m_ld = old_wb;
      for (int b = 2; b >= 0; b--) if (b != m_rb && b != old_wb) m_wb = b;
      m_wl = 0;
    end
    ev = {ph == P_WR && m_first, ph == P_RD && m_first, m_wack, m_rack};
    if (ev != 0) q.push_back('{m_cyc, ev, m_wb, m_rb, m_wl, m_rl, m_terr});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(); else model_step();
    end
  end

  // monitor: every strobe/ack the DUT shows is matched against the next expected event
  logic [3:0] d_ev;
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      d_ev = {bus.ddr_wr_req, bus.ddr_rd_req, bus.cap_line_ack, bus.disp_line_ack};
      while (q.size() != 0 && q[0].cyc < m_cyc) begin
        checks++; errors++;
        e = q.pop_front();
        $display("FAIL stale_event: expected ev=%b at cyc %0d never seen", e.ev, e.cyc);
      end
      if (d_ev != 0 || (q.size() != 0 && q[0].cyc == m_cyc)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d: got ev=%b, required none", m_cyc, d_ev);
        end else begin
          e = q.pop_front();
          if (e.cyc != m_cyc || e.ev != d_ev || e.wb != int'(bus.wr_buf_sel) || e.rb != int'(bus.rd_buf_sel) ||
              e.wl != int'(bus.wr_line_idx) || e.rl != int'(bus.rd_line_idx) || e.terr != bus.timeout_err) begin
            errors++;
            $display("FAIL event cyc=%0d: got ev=%b wb=%0d rb=%0d wl=%0d rl=%0d terr=%0d, required cyc=%0d ev=%b wb=%0d rb=%0d wl=%0d rl=%0d terr=%0d",
                     m_cyc, d_ev, bus.wr_buf_sel, bus.rd_buf_sel, bus.wr_line_idx, bus.rd_line_idx, bus.timeout_err,
                     e.cyc, e.ev, e.wb, e.rb, e.wl, e.rl, e.terr);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.cap_line_req = 0; bus.cap_frame_end = 0; bus.disp_line_req = 0;
    bus.disp_frame_start = 0; bus.disp_urgent = 0; bus.ddr_wr_beat = 0; bus.ddr_rd_beat = 0;
  endtask

  task automatic pulse(input bit cr, input bit dr, input bit cfe, input bit dfs);
    bus.cap_line_req = cr; bus.disp_line_req = dr; bus.cap_frame_end = cfe; bus.disp_frame_start = dfs;
    tick();
    bus.cap_line_req = 0; bus.disp_line_req = 0; bus.cap_frame_end = 0; bus.disp_frame_start = 0;
  endtask

  task automatic wait_strobe(output int which);
    which = 0;
    for (int i = 0; i < 30 && which == 0; i++) begin
      if (bus.ddr_wr_req) which = 1;
      else if (bus.ddr_rd_req) which = 2;
      else tick();
    end
  endtask

  task automatic feed(input bit rd, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ddr_wr_beat = !rd; bus.ddr_rd_beat = rd;
      tick();
    end
    bus.ddr_wr_beat = 0; bus.ddr_rd_beat = 0;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int w;
    bit starve;
    clr();
    tick(); tick();
    rst_n = 1;
    chk("rst_wr_buf_sel", bus.wr_buf_sel, 1);
    chk("rst_rd_buf_sel", bus.rd_buf_sel, 0);
    chk("rst_wr_line_idx", bus.wr_line_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    // single write: strobe two cycles after the request, ack the cycle after beat LP
    pulse(1, 0, 0, 0);
    tick();
    chk("wr_strobe_latency", bus.ddr_wr_req, 1);
    feed(0, LP);
    chk("wr_ack", bus.cap_line_ack, 1);
    chk("wr_line_idx_inc", bus.wr_line_idx, 1);
    tick();
    // contention and round-robin alternation
    do_reset();
    pulse(1, 1, 0, 0);
    wait_strobe(w); chk("rr1_first", w, 1); feed(0, LP);
    wait_strobe(w); chk("rr1_second", w, 2); feed(1, LP);
    pulse(1, 1, 0, 0);
    wait_strobe(w); chk("rr2_first", w, 2); feed(1, LP);
    wait_strobe(w); chk("rr2_second", w, 1); feed(0, LP);
    bus.disp_urgent = 1;
    pulse(1, 1, 0, 0);
    wait_strobe(w); chk("urgent_first", w, 2); feed(1, LP);
    wait_strobe(w); chk("urgent_second", w, 1); feed(0, LP);
    bus.disp_urgent = 0;
    tick(); tick();
    // timeout on a starved read, then retry
    do_reset();
    pulse(0, 1, 0, 0);
    repeat (9) tick();
    chk("timeout_err_set", bus.timeout_err, 1);
    chk("timeout_no_ack", bus.disp_line_ack, 0);
    chk("timeout_gap_busy", bus.busy, 1);
    tick(); tick();
    chk("timeout_retry_strobe", bus.ddr_rd_req, 1);
    feed(1, LP);
    chk("retry_ack", bus.disp_line_ack, 1);
    chk("retry_rd_line_idx", bus.rd_line_idx, 1);
    // asynchronous reset in the middle of a burst
    pulse(1, 0, 0, 0);
    tick();
    feed(0, 2);
    rst_n = 0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_timeout_err", bus.timeout_err, 0);
    chk("midrst_rd_line_idx", bus.rd_line_idx, 0);
    chk("midrst_wr_buf_sel", bus.wr_buf_sel, 1);
    tick();
    rst_n = 1;
    // triple-buffer rotation
    pulse(0, 0, 1, 0); chk("tb_wr_after_fe1", bus.wr_buf_sel, 2);
    pulse(0, 0, 0, 1); chk("tb_rd_after_fs", bus.rd_buf_sel, 1);
    pulse(0, 0, 1, 0); chk("tb_wr_after_fe2", bus.wr_buf_sel, 0);
    // frame end during a write burst is held until the ack
    pulse(1, 0, 0, 0);
    tick();
    feed(0, 1);
    pulse(0, 0, 1, 0);
    chk("fe_held_wr_buf", bus.wr_buf_sel, 0);
    feed(0, LP - 1);
    chk("fe_held_ack", bus.cap_line_ack, 1);
    chk("fe_held_line_idx", bus.wr_line_idx, 0);
    chk("fe_held_applied", bus.wr_buf_sel, 2);
    tick(); tick();
    pulse(0, 0, 0, 1); chk("fs_after_held", bus.rd_buf_sel, 0);
    pulse(0, 0, 1, 0); chk("fe_before_simul", bus.wr_buf_sel, 1);
    // simultaneous events: reader moves first, writer avoids the new read buffer
    pulse(0, 0, 1, 1);
    chk("simul_rd_buf", bus.rd_buf_sel, 2);
    chk("simul_wr_buf", bus.wr_buf_sel, 0);
    // randomized traffic, with starvation windows to provoke timeouts
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      starve = ((i / 400) % 4) == 3;
      bus.cap_line_req = $urandom_range(0, 7) == 0;
      bus.disp_line_req = $urandom_range(0, 7) == 0;
      bus.cap_frame_end = $urandom_range(0, 79) == 0;
      bus.disp_frame_start = $urandom_range(0, 79) == 0;
      if ($urandom_range(0, 19) == 0) bus.disp_urgent = ~bus.disp_urgent;
      bus.ddr_wr_beat = !starve && $urandom_range(0, 3) != 0;
      bus.ddr_rd_beat = !starve && $urandom_range(0, 3) != 0;
      tick();
    end
    clr();
    bus.ddr_wr_beat = 1; bus.ddr_rd_beat = 1;
    repeat (30) tick();
    clr();
    tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
